// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALUOp codes and datapath mux selects.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    WB_ALU    = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    WB_MEM    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    ILLEGAL   = 4'd11,
    FAULT     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // States that hold mem_req high and are guarded by the wait timer.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited for ack; flags the cycle in
// which the MEM_TIMEOUT-th unacknowledged wait is about to complete.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [7:0] cnt;

  // Wait counter: cleared on entry to a state, saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (tick && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = tick && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Main sequencer of the multi-cycle RV32I core: state register, next-state
// logic, Moore output decode, memory handshake timeout and retire counter.
module multi_cycle_control
  import multi_cycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [6:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal_o,
  output logic             bus_fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  logic   retire;
  logic   expired;
  logic   wait_clear;
  logic   wait_tick;

  assign wait_clear = (state_next != state);
  assign wait_tick  = is_mem_state(state) && !mem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (wait_clear),
    .tick    (wait_tick),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retired <= {CNT_W{1'b0}};
    end else if (retire) begin
      retired <= retired + CNT_ONE;
    end else begin
      retired <= retired;
    end
  end

  // Next-state selection and retire strobe.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ack) begin
          state_next = DECODE;
        end else if (expired) begin
          state_next = FAULT;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R:               state_next = EXEC_R;
          OP_I:               state_next = EXEC_I;
          OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
          OP_BRANCH:          state_next = BRANCH;
          OP_JAL:             state_next = JAL;
          default:            state_next = ILLEGAL;
        endcase
      end
      EXEC_R, EXEC_I: state_next = WB_ALU;
      MEM_ADDR: begin
        if (opcode == OP_LOAD) begin
          state_next = MEM_READ;
        end else begin
          state_next = MEM_WRITE;
        end
      end
      MEM_READ: begin
        if (mem_ack) begin
          state_next = WB_MEM;
        end else if (expired) begin
          state_next = FAULT;
        end else begin
          state_next = MEM_READ;
        end
      end
      MEM_WRITE: begin
        if (mem_ack) begin
          state_next = FETCH;
          retire     = 1'b1;
        end else if (expired) begin
          state_next = FAULT;
        end else begin
          state_next = MEM_WRITE;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JAL: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      ILLEGAL: state_next = FETCH;
      FAULT:   state_next = FAULT;
      default: state_next = FETCH;
    endcase
  end

  // Output decode; held at zero while reset is asserted so mem_req drops at once.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    ALUOp         = ALUOP_FUNCT;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    illegal_o     = 1'b0;
    bus_fault     = 1'b0;
    if (RST_N) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ALUOp     = ALUOP_ADD;
          ir_write  = mem_ack;
          pc_write  = mem_ack;
        end
        DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          ALUOp     = ALUOP_ADD;
        end
        EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          ALUOp     = ALUOP_FUNCT;
        end
        EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          ALUOp     = ALUOP_FUNCT;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          wb_sel    = WB_ALUOUT;
        end
        MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          ALUOp     = ALUOP_ADD;
        end
        MEM_READ: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mdr_write = mem_ack;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_RS2;
          ALUOp         = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        JAL: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_ALUOUT;
          reg_write = 1'b1;
          wb_sel    = WB_PC;
        end
        ILLEGAL: illegal_o = 1'b1;
        FAULT:   bus_fault = 1'b1;
        default: bus_fault = 1'b0;
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed, table-driven bench for multi_cycle_control built with
// MEM_TIMEOUT=4 and CNT_W=4 so timeout and counter wrap are reachable.
module tb_multi_cycle_control;

  logic       CLK;
  logic       RST_N;
  logic [6:0] opcode;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_a, alu_src_b, ALUOp, wb_sel;
  logic       reg_write, illegal_o, bus_fault;
  logic [3:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_control #(
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .opcode        (opcode),
    .mem_ack       (mem_ack),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .iord          (iord),
    .ir_write      (ir_write),
    .mdr_write     (mdr_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ALUOp         (ALUOp),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .illegal_o     (illegal_o),
    .bus_fault     (bus_fault),
    .retired       (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [19:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, ALUOp, reg_write, wb_sel,
                illegal_o, bus_fault};

  function automatic logic [19:0] mk(
    input logic req, we, io, irw, mdrw, pcw, pcwc,
    input logic [1:0] pcs, sa, sb, aop,
    input logic rw, input logic [1:0] wb, input logic ill, bf);
    return {req, we, io, irw, mdrw, pcw, pcwc, pcs, sa, sb, aop, rw, wb, ill, bf};
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic        ack;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  logic [19:0] E_ZERO, E_F_WAIT, E_F_ACK, E_DEC, E_EXR, E_EXI, E_WBA, E_MA,
               E_MR_WAIT, E_MR_ACK, E_WBM, E_MW, E_BR, E_JAL, E_ILL, E_FLT;

  task automatic check_vec(input logic [19:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_ret(input logic [3:0] exp, input string name);
    n_checks++;
    if (retired !== exp) begin
      n_fail++;
      $display("FAIL %s: retired got %0d required %0d", name, retired, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare 1 ns later.
  task automatic step(input logic [6:0] op, input logic ack, input logic [19:0] exp,
                      input string name);
    @(negedge CLK);
    opcode  = op;
    mem_ack = ack;
    #1;
    check_vec(exp, name);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N   = 1'b0;
    mem_ack = 1'b0;
    #1;
    check_vec(E_ZERO, "reset_outputs");
    check_ret(4'd0, "reset_retired");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_vec(E_F_WAIT, "post_reset_fetch");
    check_ret(4'd0, "post_reset_retired");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             req we io irw mdr pcw pcwc pcs    sa     sb     aop    rw    wb     ill bf
    E_ZERO    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0);
    E_F_WAIT  = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 0, 0);
    E_F_ACK   = mk(1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 0, 0);
    E_DEC     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 1'b0, 2'b00, 0, 0);
    E_EXR     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0);
    E_EXI     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 0, 0);
    E_WBA     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 0, 0);
    E_MA      = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 0, 0);
    E_MR_WAIT = mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0);
    E_MR_ACK  = mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0);
    E_WBM     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 0, 0);
    E_MW      = mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0);
    E_BR      = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00, 0, 0);
    E_JAL     = mk(0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 0, 0);
    E_ILL     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1, 0);
    E_FLT     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 1);

    // R-type (stray ack outside mem states must be ignored)
    tbl.push_back('{7'b0110011, 1'b1, E_F_ACK,   "r_fetch"});
    tbl.push_back('{7'b0110011, 1'b1, E_DEC,     "r_decode"});
    tbl.push_back('{7'b0110011, 1'b1, E_EXR,     "r_exec"});
    tbl.push_back('{7'b0110011, 1'b1, E_WBA,     "r_wb"});
    // I-type
    tbl.push_back('{7'b0010011, 1'b1, E_F_ACK,   "i_fetch"});
    tbl.push_back('{7'b0010011, 1'b0, E_DEC,     "i_decode"});
    tbl.push_back('{7'b0010011, 1'b0, E_EXI,     "i_exec"});
    tbl.push_back('{7'b0010011, 1'b0, E_WBA,     "i_wb"});
    // store, 1-cycle memory
    tbl.push_back('{7'b0100011, 1'b1, E_F_ACK,   "st_fetch"});
    tbl.push_back('{7'b0100011, 1'b0, E_DEC,     "st_decode"});
    tbl.push_back('{7'b0100011, 1'b0, E_MA,      "st_addr"});
    tbl.push_back('{7'b0100011, 1'b1, E_MW,      "st_write"});
    // load with ack delayed 3 cycles (ack lands on the 4th = timeout cycle)
    tbl.push_back('{7'b0000011, 1'b1, E_F_ACK,   "ld_fetch"});
    tbl.push_back('{7'b0000011, 1'b0, E_DEC,     "ld_decode"});
    tbl.push_back('{7'b0000011, 1'b0, E_MA,      "ld_addr"});
    tbl.push_back('{7'b0000011, 1'b0, E_MR_WAIT, "ld_wait1"});
    tbl.push_back('{7'b0000011, 1'b0, E_MR_WAIT, "ld_wait2"});
    tbl.push_back('{7'b0000011, 1'b0, E_MR_WAIT, "ld_wait3"});
    tbl.push_back('{7'b0000011, 1'b1, E_MR_ACK,  "ld_ack"});
    tbl.push_back('{7'b0000011, 1'b0, E_WBM,     "ld_wb"});
    // branch
    tbl.push_back('{7'b1100011, 1'b1, E_F_ACK,   "br_fetch"});
    tbl.push_back('{7'b1100011, 1'b0, E_DEC,     "br_decode"});
    tbl.push_back('{7'b1100011, 1'b0, E_BR,      "br_exec"});
    // jal
    tbl.push_back('{7'b1101111, 1'b1, E_F_ACK,   "jal_fetch"});
    tbl.push_back('{7'b1101111, 1'b0, E_DEC,     "jal_decode"});
    tbl.push_back('{7'b1101111, 1'b0, E_JAL,     "jal_exec"});
    // illegal opcode
    tbl.push_back('{7'b1111111, 1'b1, E_F_ACK,   "ill_fetch"});
    tbl.push_back('{7'b1111111, 1'b0, E_DEC,     "ill_decode"});
    tbl.push_back('{7'b1111111, 1'b0, E_ILL,     "ill_pulse"});

    RST_N   = 1'b0;
    opcode  = 7'd0;
    mem_ack = 1'b0;
    do_reset();

    foreach (tbl[i]) step(tbl[i].op, tbl[i].ack, tbl[i].exp, tbl[i].name);

    // Illegal does not retire: R, I, store, load, branch, jal = 6
    step(7'b0000000, 1'b0, E_F_WAIT, "after_ill_fetch");
    check_ret(4'd6, "retired_after_table");

    // Ack in the 4th waiting cycle beats the timeout
    step(7'b0000000, 1'b0, E_F_WAIT, "late_ack_wait2");
    step(7'b0000000, 1'b0, E_F_WAIT, "late_ack_wait3");
    step(7'b0110011, 1'b1, E_F_ACK,  "late_ack_4th");
    step(7'b0110011, 1'b0, E_DEC,    "late_ack_decode");
    step(7'b0110011, 1'b0, E_EXR,    "late_ack_exec");
    step(7'b0110011, 1'b0, E_WBA,    "late_ack_wb");

    // No ack for 4 cycles -> FAULT, frozen even if ack shows up later
    step(7'b0110011, 1'b0, E_F_WAIT, "to_wait1");
    check_ret(4'd7, "retired_before_fault");
    step(7'b0110011, 1'b0, E_F_WAIT, "to_wait2");
    step(7'b0110011, 1'b0, E_F_WAIT, "to_wait3");
    step(7'b0110011, 1'b0, E_F_WAIT, "to_wait4");
    step(7'b0110011, 1'b0, E_FLT,    "fault_enter");
    step(7'b0110011, 1'b1, E_FLT,    "fault_hold1");
    step(7'b0110011, 1'b1, E_FLT,    "fault_hold2");
    check_ret(4'd7, "retired_frozen_in_fault");

    // Reset clears the fault; then assert reset mid-MEM_WRITE between edges
    do_reset();
    step(7'b0100011, 1'b1, E_F_ACK,  "rst_st_fetch");
    step(7'b0100011, 1'b0, E_DEC,    "rst_st_decode");
    step(7'b0100011, 1'b0, E_MA,     "rst_st_addr");
    step(7'b0100011, 1'b0, E_MW,     "rst_st_wait");
    #2;
    RST_N = 1'b0;
    #1;
    check_vec(E_ZERO, "async_reset_drop");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_vec(E_F_WAIT, "restart_fetch");
    check_ret(4'd0, "restart_retired");

    // 17 R-type instructions at 4 cycles each: 15 -> 0 -> 1
    opcode  = 7'b0110011;
    mem_ack = 1'b1;
    repeat (60) @(posedge CLK);
    @(negedge CLK);
    check_ret(4'd15, "wrap_15");
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check_ret(4'd0, "wrap_0");
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check_ret(4'd1, "wrap_1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
